// File: rtl/temp_zone_monitor.sv
// temp_zone_monitor: registered temperature supervisor.
// Classifies valid samples into COLD / COOL / OK / HOT, applies exit hysteresis
// against the committed zone, debounces zone changes, pulses zone_evt on each
// committed change and tracks min/max since reset or the last stat_clr.
module temp_zone_monitor #(
    parameter int WIDTH    = 8,
    parameter int LOW_TH   = 90,
    parameter int BAND_LO  = 97,
    parameter int BAND_HI  = 100,
    parameter int HYST     = 2,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             temp_valid,
    input  logic [WIDTH-1:0] temperature,
    input  logic             stat_clr,
    output logic [1:0]       zone,
    output logic             temp_high,
    output logic             temp_state,
    output logic             temp_low,
    output logic             zone_evt,
    output logic [WIDTH-1:0] temp_max,
    output logic [WIDTH-1:0] temp_min
);

    // Zone encoding matches the external zone output.
    typedef enum logic [1:0] {
        ZONE_OK   = 2'd0,
        ZONE_COOL = 2'd1,
        ZONE_COLD = 2'd2,
        ZONE_HOT  = 2'd3
    } zone_e;

    // Debounce counter only needs to count up to DEBOUNCE-1 before committing.
    localparam int CNT_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DEBOUNCE > 0) ? DEBOUNCE - 1 : 0);

    // Thresholds carried one bit wider than the sample so LOW_TH+HYST and
    // BAND_LO+HYST never wrap.
    localparam logic [WIDTH:0] LOW_TH_C    = (WIDTH + 1)'(LOW_TH);
    localparam logic [WIDTH:0] BAND_LO_C   = (WIDTH + 1)'(BAND_LO);
    localparam logic [WIDTH:0] BAND_HI_C   = (WIDTH + 1)'(BAND_HI);
    localparam logic [WIDTH:0] HOT_EXIT_C  = (WIDTH + 1)'(BAND_HI - HYST);
    localparam logic [WIDTH:0] COLD_EXIT_C = (WIDTH + 1)'(LOW_TH + HYST);
    localparam logic [WIDTH:0] COOL_EXIT_C = (WIDTH + 1)'(BAND_LO + HYST);

    localparam logic [WIDTH-1:0] MIN_INIT = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MAX_INIT = '0;

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    if (!(LOW_TH < BAND_LO && BAND_LO <= BAND_HI)) begin : g_chk_order
        $error("temp_zone_monitor: thresholds must satisfy LOW_TH < BAND_LO <= BAND_HI");
    end
    if (DEBOUNCE < 1) begin : g_chk_debounce
        $error("temp_zone_monitor: DEBOUNCE must be at least 1");
    end
    if (!(BAND_HI + 1 < 2 ** WIDTH)) begin : g_chk_width
        $error("temp_zone_monitor: BAND_HI+1 must be representable in WIDTH bits");
    end
    if (HYST < 0 || HYST > BAND_HI - BAND_LO) begin : g_chk_hyst
        $error("temp_zone_monitor: HYST must lie in 0..BAND_HI-BAND_LO");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    zone_e             zone_q;
    zone_e             pending_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              zone_evt_q;
    logic [WIDTH-1:0]  max_q;
    logic [WIDTH-1:0]  min_q;

    logic [WIDTH:0]    temp_ext;
    zone_e             raw_zone;
    zone_e             cand_zone;
    logic              cnt_at_limit;

    assign temp_ext     = {1'b0, temperature};
    assign cnt_at_limit = (cnt_q >= CNT_LAST);

    // Raw classification of the current sample against the fixed thresholds.
    always_comb begin
        // NOTE: default assignment first so every path drives raw_zone; otherwise a latch is inferred.
        raw_zone = ZONE_OK;
        if (temp_ext < LOW_TH_C) begin
            raw_zone = ZONE_COLD;
        end else if (temp_ext < BAND_LO_C) begin
            raw_zone = ZONE_COOL;
        end else if (temp_ext <= BAND_HI_C) begin
            raw_zone = ZONE_OK;
        end else begin
            raw_zone = ZONE_HOT;
        end
    end

    // Candidate zone: raw zone with exit hysteresis relative to the committed zone.
    always_comb begin
        cand_zone = raw_zone;
        unique case (zone_q)
            ZONE_HOT: begin
                // Leaving HOT needs the sample HYST below the band top.
                if (temp_ext > HOT_EXIT_C) begin
                    cand_zone = ZONE_HOT;
                end
            end
            ZONE_COLD: begin
                // Leaving COLD needs the sample HYST above the cold threshold.
                if (temp_ext < COLD_EXIT_C) begin
                    cand_zone = ZONE_COLD;
                end
            end
            ZONE_COOL: begin
                // COOL->COLD is immediate; COOL->OK needs HYST margin into the band.
                if (raw_zone == ZONE_OK && temp_ext < COOL_EXIT_C) begin
                    cand_zone = ZONE_COOL;
                end
            end
            ZONE_OK: begin
                cand_zone = raw_zone;
            end
        endcase
    end

    // Debounce FSM: commit a new zone after DEBOUNCE consecutive agreeing valid samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zone_q     <= ZONE_OK;
            pending_q  <= ZONE_OK;
            cnt_q      <= '0;
            zone_evt_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            zone_evt_q <= 1'b0;
            if (temp_valid) begin
                if (cand_zone == zone_q) begin
                    // Sample agrees with the committed zone: any pending change is abandoned.
                    cnt_q <= '0;
                end else if (cand_zone != pending_q) begin
                    // New direction: restart counting towards this candidate.
                    pending_q <= cand_zone;
                    if (DEBOUNCE == 1) begin
                        zone_q     <= cand_zone;
                        cnt_q      <= '0;
                        zone_evt_q <= 1'b1;
                    end else begin
                        cnt_q <= CNT_ONE;
                    end
                end else if (cnt_at_limit) begin
                    // This sample completes the debounce run.
                    zone_q     <= pending_q;
                    cnt_q      <= '0;
                    zone_evt_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_ONE;
                end
            end
        end
    end

    // Min/max trackers; a coincident clear and sample seeds both with the sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= MAX_INIT;
            min_q <= MIN_INIT;
        end else if (stat_clr) begin
            if (temp_valid) begin
                max_q <= temperature;
                min_q <= temperature;
            end else begin
                max_q <= MAX_INIT;
                min_q <= MIN_INIT;
            end
        end else if (temp_valid) begin
            if (temperature > max_q) begin
                max_q <= temperature;
            end
            if (temperature < min_q) begin
                min_q <= temperature;
            end
        end
    end

    // Outputs decode only registered state, so no combinational path from the inputs.
    assign zone       = zone_q;
    assign temp_high  = (zone_q != ZONE_OK);
    assign temp_state = (zone_q == ZONE_HOT);
    assign temp_low   = (zone_q == ZONE_COLD);
    assign zone_evt   = zone_evt_q;
    assign temp_max   = max_q;
    assign temp_min   = min_q;

endmodule

// File: tb/tb_temp_zone_monitor.sv
// tb_temp_zone_monitor: table-driven bench for temp_zone_monitor with default
// parameters. Each applied vector pushes its expected outputs to a scoreboard
// queue; a monitor pops and compares one entry after every rising edge.
module tb_temp_zone_monitor;

    localparam logic [1:0] Z_OK   = 2'd0;
    localparam logic [1:0] Z_COOL = 2'd1;
    localparam logic [1:0] Z_COLD = 2'd2;
    localparam logic [1:0] Z_HOT  = 2'd3;

    typedef struct {
        logic       valid;
        logic [7:0] temp;
        logic       clr;
        logic [1:0] zone;
        logic       evt;
        logic [7:0] tmin;
        logic [7:0] tmax;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       temp_valid = 1'b0;
    logic [7:0] temperature = '0;
    logic       stat_clr = 1'b0;
    logic [1:0] zone;
    logic       temp_high;
    logic       temp_state;
    logic       temp_low;
    logic       zone_evt;
    logic [7:0] temp_max;
    logic [7:0] temp_min;

    int checks = 0;
    int errors = 0;

    vec_t tbl[$];
    vec_t sb[$];
    vec_t mon_exp;
    int   mon_idx = 0;

    temp_zone_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .temp_valid (temp_valid),
        .temperature(temperature),
        .stat_clr   (stat_clr),
        .zone       (zone),
        .temp_high  (temp_high),
        .temp_state (temp_state),
        .temp_low   (temp_low),
        .zone_evt   (zone_evt),
        .temp_max   (temp_max),
        .temp_min   (temp_min)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic add_n(input int n, input logic v, input logic [7:0] t, input logic c,
                         input logic [1:0] z, input logic e, input logic [7:0] mn,
                         input logic [7:0] mx);
        vec_t r;
        r.valid = v; r.temp = t; r.clr = c; r.zone = z; r.evt = e; r.tmin = mn; r.tmax = mx;
        for (int i = 0; i < n; i++) tbl.push_back(r);
    endtask

    // Drive one vector at the falling edge and queue its expected outputs.
    task automatic apply(input vec_t v);
        @(negedge clk);
        temp_valid  = v.valid;
        temperature = v.temp;
        stat_clr    = v.clr;
        sb.push_back(v);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_zone"},  zone, Z_OK);
        check({tag, "_high"},  temp_high, 0);
        check({tag, "_state"}, temp_state, 0);
        check({tag, "_low"},   temp_low, 0);
        check({tag, "_evt"},   zone_evt, 0);
        check({tag, "_max"},   temp_max, 0);
        check({tag, "_min"},   temp_min, 255);
    endtask

    // Scoreboard monitor: compare outputs shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_exp = sb.pop_front();
            check($sformatf("v%0d_zone", mon_idx),  zone, mon_exp.zone);
            check($sformatf("v%0d_evt", mon_idx),   zone_evt, mon_exp.evt);
            check($sformatf("v%0d_high", mon_idx),  temp_high, (mon_exp.zone != Z_OK) ? 1 : 0);
            check($sformatf("v%0d_state", mon_idx), temp_state, (mon_exp.zone == Z_HOT) ? 1 : 0);
            check($sformatf("v%0d_low", mon_idx),   temp_low, (mon_exp.zone == Z_COLD) ? 1 : 0);
            check($sformatf("v%0d_min", mon_idx),   temp_min, mon_exp.tmin);
            check($sformatf("v%0d_max", mon_idx),   temp_max, mon_exp.tmax);
            mon_idx++;
        end
    end

    initial begin
        vec_t v;

        // Steady OK samples.
        add_n(4, 1, 98, 0, Z_OK, 0, 98, 98);
        // Interrupted HOT run, then a full HOT run with a single event.
        add_n(3, 1, 105, 0, Z_OK, 0, 98, 105);
        add_n(1, 1, 98, 0, Z_OK, 0, 98, 105);
        add_n(3, 1, 105, 0, Z_OK, 0, 98, 105);
        add_n(1, 1, 105, 0, Z_HOT, 1, 98, 105);
        add_n(1, 0, 0, 0, Z_HOT, 0, 98, 105);
        // HOT exit hysteresis: 99 holds HOT, 98 leaves.
        add_n(4, 1, 99, 0, Z_HOT, 0, 98, 105);
        add_n(3, 1, 98, 0, Z_HOT, 0, 98, 105);
        add_n(1, 1, 98, 0, Z_OK, 1, 98, 105);
        add_n(1, 0, 98, 0, Z_OK, 0, 98, 105);
        // Direct OK->COLD with invalid gaps; invalid 200 must not touch max.
        add_n(1, 1, 85, 0, Z_OK, 0, 85, 105);
        add_n(1, 0, 85, 0, Z_OK, 0, 85, 105);
        add_n(1, 1, 85, 0, Z_OK, 0, 85, 105);
        add_n(1, 0, 0, 0, Z_OK, 0, 85, 105);
        add_n(1, 1, 85, 0, Z_OK, 0, 85, 105);
        add_n(1, 0, 200, 0, Z_OK, 0, 85, 105);
        add_n(1, 1, 85, 0, Z_COLD, 1, 85, 105);
        add_n(1, 0, 85, 0, Z_COLD, 0, 85, 105);
        // Alternating candidates never complete a debounce run.
        for (int i = 0; i < 5; i++) begin
            add_n(1, 1, 95, 0, Z_COLD, 0, 85, 105);
            add_n(1, 1, 105, 0, Z_COLD, 0, 85, 105);
        end
        // COLD exit hysteresis: 91 holds COLD, 92 moves to COOL.
        add_n(4, 1, 91, 0, Z_COLD, 0, 85, 105);
        add_n(3, 1, 92, 0, Z_COLD, 0, 85, 105);
        add_n(1, 1, 92, 0, Z_COOL, 1, 85, 105);
        // COOL->OK hysteresis: 97 holds COOL, 99 reaches OK.
        add_n(4, 1, 97, 0, Z_COOL, 0, 85, 105);
        add_n(3, 1, 99, 0, Z_COOL, 0, 85, 105);
        add_n(1, 1, 99, 0, Z_OK, 1, 85, 105);

        // Reset state.
        #12;
        check_reset_state("rst0");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Reach HOT, start leaving it, then reset mid-debounce.
        v = '{1, 105, 0, Z_OK, 0, 85, 105};
        for (int i = 0; i < 3; i++) apply(v);
        v = '{1, 105, 0, Z_HOT, 1, 85, 105};
        apply(v);
        v = '{1, 98, 0, Z_HOT, 0, 85, 105};
        for (int i = 0; i < 3; i++) apply(v);
        @(posedge clk);
        #2;
        temp_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_state("rst1");
        @(negedge clk);
        rst_n = 1'b1;

        // Debounce progress was discarded: three HOT samples do not commit.
        v = '{1, 105, 0, Z_OK, 0, 105, 105};
        for (int i = 0; i < 3; i++) apply(v);
        // Clear with a coincident sample seeds both trackers.
        v = '{1, 50, 1, Z_OK, 0, 50, 50};
        apply(v);
        // Clear alone restores the reset values.
        v = '{0, 0, 1, Z_OK, 0, 255, 0};
        apply(v);
        v = '{1, 60, 0, Z_OK, 0, 60, 60};
        apply(v);
        v = '{1, 70, 0, Z_OK, 0, 60, 70};
        apply(v);
        v = '{1, 80, 0, Z_COLD, 1, 60, 80};
        apply(v);
        v = '{0, 0, 0, Z_COLD, 0, 60, 80};
        apply(v);

        @(posedge clk);
        #2;
        check("sb_drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
